// File: rtl/prio_pkg.sv
// Shared definitions for the 4-line priority encoder and its receive-side decoder.
// The code map lives here only, so both ends agree on it.
package prio_pkg;

  localparam int CODE_W = 3;
  localparam int VEC_W  = 4;

  localparam logic [CODE_W-1:0] CODE_NONE = 3'b000;
  localparam logic [CODE_W-1:0] CODE_L0   = 3'b001;
  localparam logic [CODE_W-1:0] CODE_L1   = 3'b011;
  localparam logic [CODE_W-1:0] CODE_L2   = 3'b101;
  localparam logic [CODE_W-1:0] CODE_L3   = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [VEC_W-1:0] onehot;
    logic             err;
  } entry_t;

endpackage

// File: rtl/prio_code_lut.sv
// Combinational map from a 3-bit priority code to its one-hot request vector.
// Any code outside the legal set decodes to all zeros and sets err.
module prio_code_lut
  import prio_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [VEC_W-1:0]  onehot,
  output logic              err
);

  // decode one code; the default arm covers the three illegal codes
  always_comb begin
    onehot = 4'b0000;
    err    = 1'b0;
    case (code)
      CODE_NONE: begin onehot = 4'b0000; err = 1'b0; end
      CODE_L0:   begin onehot = 4'b0001; err = 1'b0; end
      CODE_L1:   begin onehot = 4'b0010; err = 1'b0; end
      CODE_L2:   begin onehot = 4'b0100; err = 1'b0; end
      CODE_L3:   begin onehot = 4'b1000; err = 1'b0; end
      default:   begin onehot = 4'b0000; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Receive-side priority code decoder with a 2-entry output buffer and a
// saturating illegal-code counter. in_ready depends on occupancy only.
module priority_code_decoder
  import prio_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           in_code,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           out_onehot,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("priority_code_decoder: BUF_DEPTH must be 2");
  end

  entry_t               lut_s;
  occ_t                 state_r, state_nxt_s;
  entry_t               head_r, head_nxt_s, tail_r, tail_nxt_s;
  logic                 in_ready_r, out_valid_r;
  logic                 push_s, pop_s;
  logic [ERR_CNT_W-1:0] err_count_r, err_count_nxt_s;

  prio_code_lut u_lut (
    .code   (in_code),
    .onehot (lut_s.onehot),
    .err    (lut_s.err)
  );

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // occupancy transitions; a simultaneous push and pop in ONE overwrites the head
  always_comb begin
    state_nxt_s = state_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          head_nxt_s  = lut_s;
          state_nxt_s = ONE;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          head_nxt_s  = lut_s;
          state_nxt_s = ONE;
        end else if (push_s) begin
          tail_nxt_s  = lut_s;
          state_nxt_s = FULL;
        end else if (pop_s) begin
          head_nxt_s  = '{onehot: 4'b0000, err: 1'b0};
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          head_nxt_s  = tail_r;
          state_nxt_s = ONE;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        head_nxt_s  = '{onehot: 4'b0000, err: 1'b0};
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // saturating illegal-code counter; clear wins over a same-cycle increment
  always_comb begin
    err_count_nxt_s = err_count_r;
    if (err_clr) begin
      err_count_nxt_s = {ERR_CNT_W{1'b0}};
    end else if (push_s && lut_s.err && (err_count_r != {ERR_CNT_W{1'b1}})) begin
      err_count_nxt_s = err_count_r + ERR_CNT_W'(1);
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // buffer storage and handshake flags, all registered from the next occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      head_r      <= '{onehot: 4'b0000, err: 1'b0};
      tail_r      <= '{onehot: 4'b0000, err: 1'b0};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

  // error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_r <= {ERR_CNT_W{1'b0}};
    end else begin
      err_count_r <= err_count_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_onehot = head_r.onehot;
  assign out_err    = head_r.err;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_priority_code_decoder.sv
// Self-checking bench: code table, directed handshake corners and randomized
// traffic against a queue-based reference of the 2-entry buffer.
module tb_priority_code_decoder;

  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_code = 3'b000;
  logic       in_valid = 1'b0, in_ready, out_valid, out_err, out_ready = 1'b0, err_clr = 1'b0;
  logic [3:0] out_onehot;
  logic [7:0] err_count;

  logic [2:0] s_code = 3'b000;
  logic       s_valid = 1'b0, s_in_ready, s_out_valid, s_err;
  logic [3:0] s_onehot;
  logic [1:0] s_count;

  int passed = 0;
  int total  = 0;

  logic [4:0] mq[$];
  int         mcnt = 0;

  always #5 clk = ~clk;

  priority_code_decoder #(.ERR_CNT_W(8), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
    .out_onehot(out_onehot), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .err_count(err_count), .err_clr(err_clr)
  );

  priority_code_decoder #(.ERR_CNT_W(2), .BUF_DEPTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_code(s_code), .in_valid(s_valid), .in_ready(s_in_ready),
    .out_onehot(s_onehot), .out_err(s_err), .out_valid(s_out_valid),
    .out_ready(1'b1), .err_count(s_count), .err_clr(1'b0)
  );

  typedef struct {
    logic [2:0] code;
    logic [3:0] exp_onehot;
    logic       exp_err;
  } vec_t;

  // legal codes: onehot bit index is code/2; even nonzero codes are illegal
  function automatic logic [4:0] ref_decode(input logic [2:0] c);
    int idx;
    if (c == 3'd0) return 5'b00000;
    if ((c % 2) == 1) begin
      idx = c / 2;
      return {4'(1 << idx), 1'b0};
    end
    return 5'b00001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_model();
    logic [4:0] h;
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("err_count", 32'(err_count), 32'(mcnt));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("out_onehot", 32'(out_onehot), 32'(h[4:1]));
      chk("out_err", 32'(out_err), 32'(h[0]));
    end
  endtask

  // one clock: drive at negedge+1, advance the model at posedge, check after negedge
  task automatic tick(input logic [2:0] code, input logic valid, input logic ordy, input logic clr);
    bit push, pop;
    logic [4:0] e;
    in_code = code; in_valid = valid; out_ready = ordy; err_clr = clr;
    push = valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && ordy;
    e    = ref_decode(code);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    if (clr) mcnt = 0;
    else if (push && e[0] && mcnt < CNT_MAX) mcnt++;
    @(negedge clk);
    #1;
    check_model();
  endtask

  vec_t tbl[8];
  int   accepts;

  initial begin
    tbl[0] = '{3'b000, 4'b0000, 1'b0};
    tbl[1] = '{3'b001, 4'b0001, 1'b0};
    tbl[2] = '{3'b011, 4'b0010, 1'b0};
    tbl[3] = '{3'b101, 4'b0100, 1'b0};
    tbl[4] = '{3'b111, 4'b1000, 1'b0};
    tbl[5] = '{3'b010, 4'b0000, 1'b1};
    tbl[6] = '{3'b100, 4'b0000, 1'b1};
    tbl[7] = '{3'b110, 4'b0000, 1'b1};

    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_onehot", 32'(out_onehot), 32'd0);
    chk("rst out_err", 32'(out_err), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // back-to-back table sweep, out_ready held high
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].code, 1'b1, 1'b1, 1'b0);
      chk("tbl onehot", 32'(out_onehot), 32'(tbl[i].exp_onehot));
      chk("tbl err", 32'(out_err), 32'(tbl[i].exp_err));
      chk("tbl valid", 32'(out_valid), 32'd1);
      if (i == 4) chk("legal err_count", 32'(err_count), 32'd0);
    end
    chk("illegal err_count", 32'(err_count), 32'd3);
    tick(3'b010, 1'b1, 1'b1, 1'b1);
    chk("clr wins", 32'(err_count), 32'd0);
    tick(3'b000, 1'b0, 1'b1, 1'b0);
    chk("drained", 32'(out_valid), 32'd0);

    // backpressure
    tick(3'b001, 1'b1, 1'b0, 1'b0);
    tick(3'b111, 1'b1, 1'b0, 1'b0);
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    tick(3'b101, 1'b1, 1'b0, 1'b0);
    chk("bp hold onehot", 32'(out_onehot), 32'h1);
    tick(3'b101, 1'b1, 1'b1, 1'b0);
    chk("bp second", 32'(out_onehot), 32'h8);
    tick(3'b101, 1'b1, 1'b1, 1'b0);
    chk("bp third", 32'(out_onehot), 32'h4);
    tick(3'b000, 1'b0, 1'b1, 1'b0);

    // continuous stream: one accept per cycle
    accepts = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) accepts++;
      tick(3'($urandom_range(7, 0)), 1'b1, 1'b1, 1'b0);
      chk("stream in_ready", 32'(in_ready), 32'd1);
    end
    chk("stream accepts", 32'(accepts), 32'd20);
    tick(3'b000, 1'b0, 1'b1, 1'b0);

    // saturation on the 2-bit counter instance
    in_valid = 1'b0;
    s_code = 3'b110;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("sat count", 32'(s_count), 32'(((i + 1) > 3) ? 3 : (i + 1)));
      chk("sat in_ready", 32'(s_in_ready), 32'd1);
    end
    s_valid = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           1'($urandom_range(15, 0) == 0));
    end

    // mid-stream reset with a full buffer
    tick(3'b000, 1'b0, 1'b1, 1'b1);
    tick(3'b000, 1'b0, 1'b1, 1'b0);
    tick(3'b010, 1'b1, 1'b0, 1'b0);
    tick(3'b110, 1'b1, 1'b0, 1'b0);
    chk("full before rst", 32'(in_ready), 32'd0);
    chk("count before rst", 32'(err_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst err_count", 32'(err_count), 32'd0);
    chk("async rst onehot", 32'(out_onehot), 32'd0);
    chk("async rst err", 32'(out_err), 32'd0);
    mq.delete();
    mcnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick(3'b000, 1'b0, 1'b1, 1'b0);
      chk("no stale entry", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/priority_code_decoder.md
Name: priority_code_decoder

Overview:
- Receive-side counterpart of the 4-bit priority encoder. Accepts a stream of 3-bit priority codes under a valid/ready handshake and reconstructs the canonical 4-bit one-hot of the winning request line.
- Flags and counts illegal codes.
- Contains a 2-entry output buffer so the upstream encoder stage is never throttled combinationally by downstream ready.

Parameters:
- ERR_CNT_W, 8, width of the saturating illegal-code counter.
- BUF_DEPTH, 2, output buffer depth; fixed at 2. Any other value is a synthesis-time error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_code  input  3  encoded priority code
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept a code this cycle
- out_onehot  output  4  decoded one-hot request vector (all zeros = no request)
- out_err  output  1  the entry presented was an illegal code
- out_valid  output  1  out_onehot/out_err are valid
- out_ready  input  1  downstream accepts the entry this cycle
- err_count  output  ERR_CNT_W  saturating count of illegal codes accepted
- err_clr  input  1  synchronous clear of err_count

Behaviour:
- Reset: asynchronous, active-high. Buffer empties immediately. Resulting output values:
  - out_valid=0, out_onehot=0000, out_err=0
  - err_count=0
  - in_ready=1 after reset deasserts
- Code map (legal codes):
  - 000 -> 0000
  - 001 -> 0001
  - 011 -> 0010
  - 101 -> 0100
  - 111 -> 1000
- Illegal codes are 010, 100 and 110. Each produces out_onehot=0000 with out_err=1.
- An X/Z bit on in_code while in_valid=1 is a bench error and is not handled in RTL.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: a code accepted in cycle N appears on the outputs in cycle N+1 if the buffer was empty. Otherwise it appears in FIFO order.
- Buffer: 2-entry FIFO of {onehot[3:0], err}. Decode happens before the write, so stored entries are already decoded.
- State machine is occupancy-based, with states EMPTY, ONE and FULL:
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input transfer only -> FULL.
    - Output transfer only -> EMPTY.
    - Both in the same cycle -> stays ONE, head replaced by the new entry.
  - FULL: out_valid=1, in_ready=0. Output transfer -> ONE, second entry moves to head.
- in_ready is a registered function of state only. It has no combinational path from out_ready.
- While out_valid=1 and out_ready=0, out_onehot and out_err are held stable.
- err_count:
  - Increments by 1 on each input transfer of an illegal code.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr takes priority over an increment in the same cycle; the count becomes 0.
- Reset asserted mid-stream: all buffered entries are discarded. No partial output is presented after reset.
- in_valid while in_ready=0 is ignored. Upstream must hold the code until it is accepted.

Decomposition:
- Shared package prio_pkg holds:
  - code width 3 and vector width 4
  - localparams for the five legal codes
  - the occupancy state enum {EMPTY, ONE, FULL}
- The encoder and this decoder both import the package so the code map has a single source.
- One sub-module, prio_code_lut: a purely combinational map of code[2:0] to {onehot[3:0], err}. It is reusable by a future checker.

Test Plan:
- Reset then legal sweep: hold out_ready=1 and send 000, 001, 011, 101, 111 back-to-back. Required: outputs 0000, 0001, 0010, 0100, 1000 one cycle after each accept, out_err=0 throughout, err_count=0.
- Illegal codes: send 010, 100, 110. Required: out_onehot=0000 with out_err=1 for each, err_count=3. Then pulse err_clr together with another 010 accept; required: err_count=0.
- Backpressure:
  - Hold out_ready=0 and send 001 then 111. Required: in_ready drops to 0 the cycle after the second accept.
  - While in_ready=0, present 101. Required: 101 is not accepted, out_onehot stays 0001.
  - Release out_ready. Required: 0001 then 1000, then 101 is accepted and 0100 follows.
- Simultaneous push/pop in ONE: out_ready=1 with a continuous stream. Required: in_ready stays 1 and throughput is one code per cycle.
- Saturation: ERR_CNT_W=2, send 5 illegal codes. Required: err_count stops at 3.
- Mid-stream reset: with FULL occupancy, pulse rst between clock edges. Required: out_valid=0 and err_count=0 immediately, no stale entry emitted afterward.
